// File: rtl/dcr_issue_unit_pkg.sv
// Shared types and constants for the DCR issue unit: request payload, FSM states,
// and the default legal base-state address window.
package dcr_issue_unit_pkg;

  localparam int DCR_ADDR_WIDTH = 12;
  localparam int DCR_DATA_WIDTH = 32;

  localparam logic [DCR_ADDR_WIDTH-1:0] DCR_BASE_STATE_BEGIN = 12'h001;
  localparam logic [DCR_ADDR_WIDTH-1:0] DCR_BASE_STATE_END   = 12'h009;

  typedef struct packed {
    logic [DCR_ADDR_WIDTH-1:0] addr;
    logic [DCR_DATA_WIDTH-1:0] data;
  } dcr_req_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } dcr_issue_state_t;

  // Half-open window: lo inclusive, hi exclusive.
  function automatic logic addr_in_range(
    input logic [DCR_ADDR_WIDTH-1:0] addr,
    input logic [DCR_ADDR_WIDTH-1:0] lo,
    input logic [DCR_ADDR_WIDTH-1:0] hi
  );
    return (addr >= lo) && (addr < hi);
  endfunction

endpackage

// File: rtl/dcr_issue_unit_if.sv
// DCR write bus seen by the clusters: single-cycle, non-backpressured write pulses.
interface VX_dcr_bus_if;
  import dcr_issue_unit_pkg::*;

  logic                      write_valid;
  logic [DCR_ADDR_WIDTH-1:0] write_addr;
  logic [DCR_DATA_WIDTH-1:0] write_data;

  modport master (output write_valid, output write_addr, output write_data);
  modport slave  (input  write_valid, input  write_addr, input  write_data);

endinterface

// File: rtl/dcr_issue_unit_fifo.sv
// Power-of-two circular FIFO with an occupancy counter; head entry is visible
// combinationally on data_out. Callers never push when full or pop when empty.
module VX_fifo_queue #(
  parameter  int DATAW = 1,
  parameter  int DEPTH = 4,
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic [CNTW-1:0]  size
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATAW-1:0] mem [DEPTH];
  logic [PTRW-1:0]  rd_ptr;
  logic [PTRW-1:0]  wr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      size   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTRW'(1);
      if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
      if (push && !pop)      size <= size + CNTW'(1);
      else if (pop && !push) size <= size - CNTW'(1);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  assign data_out = mem[rd_ptr];
  assign empty    = (size == '0);
  assign full     = (size == CNTW'(DEPTH));

endmodule

// File: rtl/dcr_issue_unit.sv
// Host-side DCR write master: buffers range-checked write requests and replays
// them on the DCR bus as single-cycle pulses with a minimum idle spacing.
//
// state    | meaning
// ST_IDLE  | nothing in flight; pop head as soon as the FIFO is non-empty
// ST_ISSUE | write_valid high for this cycle with the popped entry
// ST_GAP   | enforced idle spacing; gap_cnt counts down to 0
module dcr_issue_unit
  import dcr_issue_unit_pkg::*;
#(
  parameter  int                        DEPTH      = 4,
  parameter  int                        GAP        = 1,
  parameter  logic [DCR_ADDR_WIDTH-1:0] ADDR_BEGIN = DCR_BASE_STATE_BEGIN,
  parameter  logic [DCR_ADDR_WIDTH-1:0] ADDR_END   = DCR_BASE_STATE_END,
  localparam int                        CNTW       = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  input  logic [DCR_ADDR_WIDTH-1:0] req_addr,
  input  logic [DCR_DATA_WIDTH-1:0] req_data,
  output logic                      req_ready,
  VX_dcr_bus_if.master              dcr_bus_if,
  output logic [CNTW-1:0]           pending,
  output logic [7:0]                err_count,
  output logic                      busy
);

  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  dcr_issue_state_t state, state_n;
  logic [3:0]       gap_cnt, gap_cnt_n;
  logic             fifo_empty, fifo_full;
  logic             accept, legal, push, pop;
  dcr_req_t         req_in, head;

  // fifo_full comes from the registered occupancy, so ready never follows req_valid.
  assign req_ready = !fifo_full;
  assign accept    = req_valid && req_ready;
  assign legal     = addr_in_range(req_addr, ADDR_BEGIN, ADDR_END);
  assign push      = accept && legal;
  assign req_in    = '{addr: req_addr, data: req_data};

  VX_fifo_queue #(
    .DATAW ($bits(dcr_req_t)),
    .DEPTH (DEPTH)
  ) fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .data_in  (req_in),
    .data_out (head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .size     (pending)
  );

  always_comb begin
    state_n   = state;
    gap_cnt_n = gap_cnt;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (GAP > 0) begin
          state_n   = ST_GAP;
          gap_cnt_n = GAP_LOAD;
        end else if (!fifo_empty) begin
          pop = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt == 4'd0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_n = ST_ISSUE;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          gap_cnt_n = gap_cnt - 4'd1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      gap_cnt <= 4'd0;
    end else begin
      state   <= state_n;
      gap_cnt <= gap_cnt_n;
    end
  end

  // A pop always lands in ST_ISSUE, so the pulse is simply the registered pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dcr_bus_if.write_valid <= 1'b0;
      dcr_bus_if.write_addr  <= '0;
      dcr_bus_if.write_data  <= '0;
    end else begin
      dcr_bus_if.write_valid <= pop;
      if (pop) begin
        dcr_bus_if.write_addr <= head.addr;
        dcr_bus_if.write_data <= head.data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= 8'd0;
    end else if (accept && !legal && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

  assign busy = !fifo_empty || (state != ST_IDLE);

endmodule

// File: tb/tb_dcr_issue_unit.sv
// Bench for dcr_issue_unit: three instances (GAP=1, GAP=2, GAP=0) checked every
// cycle against a timing-rule model, plus directed literal expectations.
module tb_dcr_issue_unit;
  import dcr_issue_unit_pkg::*;

  localparam int N     = 3;
  localparam int DEPTH = 4;

  function automatic int gap_of(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      default: return 0;
    endcase
  endfunction

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid [N];
  logic [11:0] req_addr  [N];
  logic [31:0] req_data  [N];
  logic        rdy  [N];
  logic [2:0]  pend [N];
  logic [7:0]  errc [N];
  logic        bsy  [N];
  logic        wv   [N];
  logic [11:0] wa   [N];
  logic [31:0] wd   [N];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  VX_dcr_bus_if bus0 ();
  VX_dcr_bus_if bus1 ();
  VX_dcr_bus_if bus2 ();

  dcr_issue_unit #(.DEPTH(DEPTH), .GAP(1)) u0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_addr(req_addr[0]),
    .req_data(req_data[0]), .req_ready(rdy[0]), .dcr_bus_if(bus0),
    .pending(pend[0]), .err_count(errc[0]), .busy(bsy[0]));
  dcr_issue_unit #(.DEPTH(DEPTH), .GAP(2)) u1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_addr(req_addr[1]),
    .req_data(req_data[1]), .req_ready(rdy[1]), .dcr_bus_if(bus1),
    .pending(pend[1]), .err_count(errc[1]), .busy(bsy[1]));
  dcr_issue_unit #(.DEPTH(DEPTH), .GAP(0)) u2 (
    .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_addr(req_addr[2]),
    .req_data(req_data[2]), .req_ready(rdy[2]), .dcr_bus_if(bus2),
    .pending(pend[2]), .err_count(errc[2]), .busy(bsy[2]));

  assign wv[0] = bus0.write_valid; assign wa[0] = bus0.write_addr; assign wd[0] = bus0.write_data;
  assign wv[1] = bus1.write_valid; assign wa[1] = bus1.write_addr; assign wd[1] = bus1.write_data;
  assign wv[2] = bus2.write_valid; assign wa[2] = bus2.write_addr; assign wd[2] = bus2.write_data;

  // Model: legal requests queue up; the head may leave on edge e when it was
  // accepted on an earlier edge and e is at least GAP+1 edges after the last issue.
  int          m_head [N];
  int          m_tail [N];
  int          m_last [N];
  int          m_err  [N];
  logic [11:0] m_qa   [N][32];
  logic [31:0] m_qd   [N][32];
  logic        m_wv   [N];
  logic [11:0] m_wa   [N];
  logic [31:0] m_wd   [N];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        m_head[k] = 0; m_tail[k] = 0; m_last[k] = -100; m_err[k] = 0;
        m_wv[k] = 1'b0; m_wa[k] = '0; m_wd[k] = '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int e;
        int occ;
        e   = cyc + 1;
        occ = m_tail[k] - m_head[k];
        if (occ > 0 && e >= m_last[k] + gap_of(k) + 1) begin
          m_wv[k] = 1'b1;
          m_wa[k] = m_qa[k][m_head[k] % 32];
          m_wd[k] = m_qd[k][m_head[k] % 32];
          m_head[k]++;
          m_last[k] = e;
        end else begin
          m_wv[k] = 1'b0;
        end
        if (req_valid[k] && occ < DEPTH) begin
          if (req_addr[k] >= 12'h001 && req_addr[k] < 12'h009) begin
            m_qa[k][m_tail[k] % 32] = req_addr[k];
            m_qd[k][m_tail[k] % 32] = req_data[k];
            m_tail[k]++;
          end else if (m_err[k] < 255) begin
            m_err[k]++;
          end
        end
      end
    end
  end

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d at cycle %0d: got %0h, expected %0h", name, k, cyc, act, exp);
    end
  endtask

  int          log_n    [N];
  int          log_t    [N][64];
  logic [11:0] log_a    [N][64];
  int          max_pend [N];

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      int occ;
      occ = m_tail[k] - m_head[k];
      check("write_valid", k, 32'(wv[k]), 32'(m_wv[k]));
      check("write_addr",  k, 32'(wa[k]), 32'(m_wa[k]));
      check("write_data",  k, wd[k], m_wd[k]);
      check("pending",     k, 32'(pend[k]), 32'(occ));
      check("req_ready",   k, 32'(rdy[k]), 32'(occ < DEPTH));
      check("err_count",   k, 32'(errc[k]), 32'(m_err[k]));
      check("busy",        k, 32'(bsy[k]), 32'(occ > 0 || cyc <= m_last[k] + gap_of(k)));
      if (wv[k] === 1'b1 && log_n[k] < 64) begin
        log_t[k][log_n[k]] = cyc;
        log_a[k][log_n[k]] = wa[k];
        log_n[k]++;
      end
      if (int'(pend[k]) > max_pend[k]) max_pend[k] = int'(pend[k]);
    end
  end

  task automatic clear_log(input int k);
    log_n[k]    = 0;
    max_pend[k] = 0;
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance with
  // req_valid still high so consecutive calls stream one request per cycle.
  task automatic push(input int k, input logic [11:0] a, input logic [31:0] d);
    int w;
    w = 0;
    req_valid[k] = 1'b1; req_addr[k] = a; req_data[k] = d;
    while (rdy[k] !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (rdy[k] !== 1'b1) begin
      errors++;
      $display("FAIL push_handshake dut%0d: req_ready=%b after %0d cycles, expected 1", k, rdy[k], w);
      req_valid[k] = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      req_valid[k] = 1'b0; req_addr[k] = '0; req_data[k] = '0;
      log_n[k] = 0; max_pend[k] = 0;
    end
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_write_valid", 0, 32'(wv[0]), 0);
    check("rst_write_addr",  0, 32'(wa[0]), 0);
    check("rst_write_data",  0, wd[0], 0);
    check("rst_req_ready",   0, 32'(rdy[0]), 1);
    check("rst_pending",     0, 32'(pend[0]), 0);
    check("rst_err_count",   0, 32'(errc[0]), 0);
    check("rst_busy",        0, 32'(bsy[0]), 0);
    reset = 1'b1;
    @(negedge clk);

    // Single write, GAP=1
    clear_log(0);
    push(0, 12'h001, 32'hDEADBEEF);
    req_valid[0] = 1'b0;
    check("single_pending", 0, 32'(pend[0]), 1);
    check("single_no_early_pulse", 0, 32'(wv[0]), 0);
    @(negedge clk);
    check("single_pulse", 0, 32'(wv[0]), 1);
    check("single_addr",  0, 32'(wa[0]), 32'h001);
    check("single_data",  0, wd[0], 32'hDEADBEEF);
    @(negedge clk);
    check("single_gap_idle", 0, 32'(wv[0]), 0);
    check("single_gap_busy", 0, 32'(bsy[0]), 1);
    check("single_addr_hold", 0, 32'(wa[0]), 32'h001);
    @(negedge clk);
    check("single_busy_fall", 0, 32'(bsy[0]), 0);
    repeat (3) @(negedge clk);
    check("single_pulse_count", 0, log_n[0], 1);

    // Burst of 6, GAP=2
    clear_log(1);
    for (int i = 0; i < 6; i++) push(1, 12'h001 + 12'(i), 32'hA0000000 + 32'(i));
    check("burst_ready_low_when_full", 1, 32'(rdy[1]), 0);
    check("burst_pending_full", 1, 32'(pend[1]), 4);
    req_valid[1] = 1'b0;
    repeat (25) @(negedge clk);
    check("burst_count", 1, log_n[1], 6);
    for (int i = 0; i < 6 && i < log_n[1]; i++) begin
      check("burst_order", 1, 32'(log_a[1][i]), 32'h001 + 32'(i));
      if (i > 0) check("burst_spacing", 1, log_t[1][i] - log_t[1][i-1], 3);
    end

    // GAP=0, back-to-back
    clear_log(2);
    for (int i = 0; i < 4; i++) push(2, 12'h004 + 12'(i), 32'h0BAD0000 + 32'(i));
    req_valid[2] = 1'b0;
    repeat (8) @(negedge clk);
    check("gap0_count", 2, log_n[2], 4);
    for (int i = 1; i < 4 && i < log_n[2]; i++)
      check("gap0_consecutive", 2, log_t[2][i] - log_t[2][i-1], 1);
    check("gap0_max_pending_le2", 2, 32'(max_pend[2] <= 2), 1);

    // Out-of-range addresses
    clear_log(0);
    push(0, 12'h009, 32'h11111111);
    push(0, 12'h005, 32'h5555AAAA);
    push(0, 12'h000, 32'h22222222);
    req_valid[0] = 1'b0;
    check("oor_err_count", 0, 32'(errc[0]), 2);
    repeat (8) @(negedge clk);
    check("oor_issue_count", 0, log_n[0], 1);
    check("oor_issue_addr", 0, 32'(log_a[0][0]), 32'h005);
    for (int i = 0; i < 300; i++) push(0, 12'hFFF, 32'(i));
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("oor_err_saturate", 0, 32'(errc[0]), 255);

    // Reset during an ISSUE cycle with 3 entries queued
    clear_log(1);
    for (int i = 0; i < 5; i++) push(1, 12'h002 + 12'(i), 32'hC0DE0000 + 32'(i));
    req_valid[1] = 1'b0;
    check("rstmid_in_issue", 1, 32'(wv[1]), 1);
    check("rstmid_queued", 1, 32'(pend[1]), 3);
    #2 reset = 1'b0;
    #1;
    check("rstmid_valid_drop", 1, 32'(wv[1]), 0);
    check("rstmid_pending_clear", 1, 32'(pend[1]), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    clear_log(1);
    repeat (12) @(negedge clk);
    check("rstmid_no_stale_write", 1, log_n[1], 0);
    check("rstmid_pending_after", 1, 32'(pend[1]), 0);
    check("rstmid_busy_after", 1, 32'(bsy[1]), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcr_issue_unit.md
# dcr_issue_unit

Host-side DCR write master that drives the DCR bus consumed by every cluster. It accepts DCR write requests over a valid/ready handshake and buffers them in a small FIFO. It range-checks each address and replays the accepted writes onto the non-backpressured `VX_dcr_bus_if` as single-cycle pulses, with a programmable minimum spacing between pulses. It sits between the AFU/host command path and the cluster DCR inputs.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `GAP`, 1: minimum idle cycles between two issued writes; range 0..15.
- `ADDR_BEGIN`, `` `VX_DCR_BASE_STATE_BEGIN ``: lowest legal address (inclusive).
- `ADDR_END`, `` `VX_DCR_BASE_STATE_END ``: upper address bound (exclusive).

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset (asserted at 0); one clock domain
- `req_valid`  in  1  write request valid
- `req_addr`  in  `` `VX_DCR_ADDR_WIDTH ``  DCR address
- `req_data`  in  `` `VX_DCR_DATA_WIDTH ``  DCR data
- `req_ready`  out  1  request accepted when high together with `req_valid`
- `dcr_bus_if`  `VX_dcr_bus_if.master`  carries `write_valid`, `write_addr`, `write_data`
- `pending`  out  `$clog2(DEPTH+1)`  number of FIFO entries occupied
- `err_count`  out  8  saturating count of dropped out-of-range requests
- `busy`  out  1  high when the FIFO is non-empty or the FSM is not IDLE

## Operation
- Handshake:
  - `req_ready = (pending != DEPTH)`, decoded from registered state only; it never depends on `req_valid`.
  - A request is accepted when `req_valid && req_ready`.
- Range check is done at acceptance. The legal window is `ADDR_BEGIN <= addr < ADDR_END`.
  - Legal request: pushed into the FIFO.
  - Illegal request: consumes the handshake but is not pushed. `err_count` increments and saturates at 255.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head and go to ISSUE.
  - ISSUE: `write_valid=1` for exactly one cycle with the popped address and data. Then go to GAP if `GAP>0`. Otherwise, if the FIFO is non-empty, pop and stay in ISSUE; else go to IDLE.
  - GAP: a down-counter loads `GAP-1`. When it reaches 0, pop and go to ISSUE if the FIFO is non-empty; else go to IDLE.
- Simultaneous push and pop:
  - `pending` stays unchanged.
  - When the FIFO is full, a pop in that cycle does not raise `req_ready` in the same cycle.
- Issue order equals acceptance order of legal requests. No merging and no reordering.
- `write_addr` and `write_data` hold their last values when `write_valid=0`.

## Timing
- Reset values:
  - `write_valid` = 0
  - `write_addr` = 0
  - `write_data` = 0
  - `req_ready` = 1
  - `pending` = 0
  - `err_count` = 0
  - `busy` = 0
  - FSM = IDLE
  - GAP counter = 0
- Latency: a legal request accepted at edge t with an empty FIFO and the FSM in IDLE is popped at t+1 and appears on `write_valid` in cycle t+2. All bus outputs are registered.
- Throughput: one write per `GAP+1` cycles in steady state. With `GAP=0`, writes issue back-to-back at one per cycle.
- `busy` remains high through the final GAP window.
- Reset asserted mid-operation:
  - All state clears asynchronously; queued writes are discarded.
  - `write_valid` drops immediately, even within an ISSUE cycle.
- Reset deassertion is synchronized externally. The block must not issue a write in the first cycle after release.

## Structure
- `VX_gpu_pkg` gains `typedef struct packed { addr; data; } dcr_req_t`, sized by `` `VX_DCR_ADDR_WIDTH `` / `` `VX_DCR_DATA_WIDTH ``, together with the FSM state enum `dcr_issue_state_t`.
- One sub-module: the storage, implemented as an instance of `VX_fifo_queue` (DATAW = `$bits(dcr_req_t)`, DEPTH). The FSM, GAP counter, range check and `err_count` stay in the top.
- Target size: roughly 150–200 lines of RTL.

## Test plan
- Single write, GAP=1:
  - Stimulus: push addr=`ADDR_BEGIN`, data=0xDEADBEEF.
  - Required: exactly one `write_valid` pulse, two cycles after acceptance, with matching addr/data; `busy` falls after the GAP cycle.
- Burst of 6 writes, DEPTH=4, GAP=2:
  - Required: `req_ready` deasserts when `pending`=4.
  - Required: writes issue in order, exactly 3 cycles apart; all 6 arrive with no loss.
- GAP=0, 4 back-to-back pushes:
  - Required: 4 consecutive `write_valid` cycles.
  - Required: `pending` never exceeds 2 when pushes arrive one per cycle.
- Out-of-range addresses:
  - Stimulus: push `ADDR_END` and `ADDR_BEGIN-1` interleaved with one legal write.
  - Required: both illegal requests handshake; `err_count`=2; only the legal write issues.
  - Required: 300 illegal pushes leave `err_count` saturated at 255.
- Reset mid-burst:
  - Stimulus: assert `reset`=0 during an ISSUE cycle with 3 entries queued.
  - Required: `write_valid` drops in the same cycle; after release, `pending`=0, `busy`=0, and no stale write issues.
